// File: rtl/lc3_arb_pkg.sv
// Shared types and constants for the LC-3 memory-port arbiter.
package lc3_arb_pkg;

   localparam int ADDR_W         = 16;
   localparam int DATA_W         = 16;
   localparam int STARVE_MAX_DEF = 4;
   localparam int TIMEOUT_DEF    = 16;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_e;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_e;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter view, master = environment view.
interface lc3_mem_arbiter_if;
   import lc3_arb_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              mem_complete;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_complete,
      output if_done, if_rdata, d_done, d_rdata, mem_addr, mem_rd, mem_wr, mem_din
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_complete,
      input  if_done, if_rdata, d_done, d_rdata, mem_addr, mem_rd, mem_wr, mem_din
   );

endinterface

// File: rtl/lc3_arb_timer.sv
// Transaction watchdog: counts busy cycles since the last grant; used with LC3_ARB_TIMEOUT_EN.
module lc3_arb_timer
   import lc3_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   logic [7:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)   r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + 8'd1;
   end

   assign o_expired = i_en && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one LC-3 memory port between fetch and data requesters; data wins unless fetch is starved.
// Optional transaction timeout enabled by defining LC3_ARB_TIMEOUT_EN.
module lc3_mem_arbiter
   import lc3_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   lc3_mem_arbiter_if.slave  bus,
   output logic              o_busy,
   output logic              o_err
);

   arb_state_e        r_state;
   arb_owner_e        r_owner;
   logic [3:0]        r_starve_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_mem_din;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_done;
   logic              r_d_done;

   logic              w_idle;
   logic              w_grant_d;
   logic              w_grant_i;
   logic              w_expired;
   logic              w_finish;
   logic [DATA_W-1:0] w_rdata;

   assign w_idle    = (r_state == IDLE);
   assign w_grant_d = w_idle && bus.d_req && (!bus.if_req || (r_starve_cnt < 4'(STARVE_MAX)));
   assign w_grant_i = w_idle && !w_grant_d && bus.if_req;

`ifdef LC3_ARB_TIMEOUT_EN
   logic r_err;

   lc3_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (w_grant_d | w_grant_i),
      .i_en      (!w_idle),
      .o_expired (w_expired)
   );

   // A completion arriving on the expiry cycle is a normal finish, not an error.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)                            r_err <= 1'b0;
      else if (w_expired && !bus.mem_complete) r_err <= 1'b1;
   end

   assign o_err = r_err;
`else
   assign w_expired = 1'b0;
   assign o_err     = 1'b0;
`endif

   assign w_finish = !w_idle && (bus.mem_complete || w_expired);
   assign w_rdata  = bus.mem_complete ? bus.mem_dout : '0;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= IDLE;
         r_owner      <= OWN_I;
         r_starve_cnt <= '0;
         r_mem_addr   <= '0;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_din    <= '0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
         r_if_done    <= 1'b0;
         r_d_done     <= 1'b0;
      end else begin
         r_if_done <= 1'b0;
         r_d_done  <= 1'b0;

         if (w_idle) begin
            if (w_grant_i)
               r_starve_cnt <= '0;
            else if (w_grant_d && bus.if_req)
               r_starve_cnt <= (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;
            else if (!bus.if_req)
               r_starve_cnt <= '0;
         end

         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_state    <= BUSY_D;
                  r_owner    <= OWN_D;
                  r_mem_addr <= bus.d_addr;
                  r_mem_rd   <= !bus.d_we;
                  r_mem_wr   <= bus.d_we;
                  r_mem_din  <= bus.d_wdata;
               end else if (w_grant_i) begin
                  r_state    <= BUSY_I;
                  r_owner    <= OWN_I;
                  r_mem_addr <= bus.if_addr;
                  r_mem_rd   <= 1'b1;
                  r_mem_wr   <= 1'b0;
                  r_mem_din  <= bus.d_wdata;
               end
            end
            BUSY_I, BUSY_D: begin
               if (w_finish) begin
                  r_state  <= IDLE;
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  if (r_owner == OWN_I) begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= w_rdata;
                  end else begin
                     r_d_done <= 1'b1;
                     if (r_mem_rd) r_d_rdata <= w_rdata;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_rd   = r_mem_rd;
   assign bus.mem_wr   = r_mem_wr;
   assign bus.mem_din  = r_mem_din;
   assign bus.if_done  = r_if_done;
   assign bus.if_rdata = r_if_rdata;
   assign bus.d_done   = r_d_done;
   assign bus.d_rdata  = r_d_rdata;
   assign o_busy       = !w_idle;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: expected grants and read data queued at stimulus, checked at the bus.
module tb_lc3_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, err;

   lc3_mem_arbiter_if bus();

   lc3_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus.slave),
      .o_busy  (busy),
      .o_err   (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic        wr;
      logic [15:0] din;
   } gnt_t;

   gnt_t        q_gnt[$];
   logic [15:0] q_if[$];
   logic [15:0] q_d[$];
   logic [15:0] mem [logic [15:0]];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          mem_auto = 1'b1;
   logic        prev_stb = 1'b0;
   gnt_t        g;
   logic [15:0] e;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic gnt_t mkg(input logic [15:0] a, input logic rd, input logic wr, input logic [15:0] din);
      gnt_t t;
      t.addr = a; t.rd = rd; t.wr = wr; t.din = din;
      return t;
   endfunction

   // memory model: completes one cycle after a strobe appears, one-cycle complete pulse
   always @(posedge clk) begin
      #1;
      if (bus.mem_complete) bus.mem_complete = 1'b0;
      else if (mem_auto && (bus.mem_rd || bus.mem_wr)) begin
         if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_din;
         bus.mem_dout = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 16'h0000;
         bus.mem_complete = 1'b1;
      end
   end

   // monitor: grants on rising strobe, read data on done pulses
   always @(negedge clk) begin
      if ((bus.mem_rd || bus.mem_wr) && !prev_stb) begin
         chk("strobe_excl", {31'b0, bus.mem_rd & bus.mem_wr}, 0);
         if (q_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
         else begin
            g = q_gnt.pop_front();
            chk("gnt_addr", bus.mem_addr, g.addr);
            chk("gnt_rd", bus.mem_rd, g.rd);
            chk("gnt_wr", bus.mem_wr, g.wr);
            if (g.wr) chk("gnt_din", bus.mem_din, g.din);
         end
      end
      prev_stb = bus.mem_rd || bus.mem_wr;
      if (bus.if_done) begin
         if (q_if.size() == 0) chk("if_done_unexpected", 1, 0);
         else begin e = q_if.pop_front(); chk("if_rdata", bus.if_rdata, e); end
      end
      if (bus.d_done) begin
         if (q_d.size() == 0) chk("d_done_unexpected", 1, 0);
         else begin e = q_d.pop_front(); chk("d_rdata", bus.d_rdata, e); end
      end
   end

   task automatic wait_done(input bit is_d, output int cyc);
      bit hit;
      cyc = 0;
      hit = 0;
      while (!hit && cyc < 64) begin
         @(negedge clk);
         cyc++;
         hit = is_d ? bus.d_done : bus.if_done;
      end
      if (!hit) chk("done_wait_bound", 0, 1);
   endtask

   task automatic fetch(input logic [15:0] a, input logic [15:0] exp, output int cyc);
      q_gnt.push_back(mkg(a, 1'b1, 1'b0, 16'h0));
      q_if.push_back(exp);
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      wait_done(1'b0, cyc);
      bus.if_req  = 1'b0;
   endtask

   task automatic dacc(input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp, output int cyc);
      q_gnt.push_back(mkg(a, !we, we, wd));
      q_d.push_back(exp);
      bus.d_we    = we;
      bus.d_addr  = a;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
      wait_done(1'b1, cyc);
      bus.d_req   = 1'b0;
   endtask

   initial begin
      int cyc;
      int nd;
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = 0; bus.d_wdata = 0; bus.mem_dout = 0; bus.mem_complete = 0;
      mem[16'h3000] = 16'h1261;
      mem[16'h5000] = 16'h6000;
      mem[16'h6000] = 16'h00AA;
      mem[16'h4100] = 16'h0077;
      mem[16'h3002] = 16'h5A5A;
      mem[16'h3004] = 16'h0E01;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_mem_wr", bus.mem_wr, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_if_done", bus.if_done, 0);
      chk("rst_d_done", bus.d_done, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // fetch only
      fetch(16'h3000, 16'h1261, cyc);
      chk("if_latency", cyc, 2);
      @(negedge clk);
      chk("idle_after_fetch", busy, 0);

      // data write: d_rdata keeps its previous value
      dacc(1'b1, 16'h4000, 16'hBEEF, 16'h0000, cyc);
      chk("d_latency", cyc, 2);
      chk("mem_written", mem.exists(16'h4000) ? mem[16'h4000] : 16'h0, 16'hBEEF);

      // indirect load: two back-to-back data reads
      dacc(1'b0, 16'h5000, 16'h0, 16'h6000, cyc);
      dacc(1'b0, 16'h6000, 16'h0, 16'h00AA, cyc);
      chk("ldi_final", bus.d_rdata, 16'h00AA);

      // simultaneous requests, data held: 4 data grants, 1 fetch, then data again
      repeat (4) q_gnt.push_back(mkg(16'h4100, 1'b1, 1'b0, 16'h0));
      q_gnt.push_back(mkg(16'h3002, 1'b1, 1'b0, 16'h0));
      q_gnt.push_back(mkg(16'h4100, 1'b1, 1'b0, 16'h0));
      repeat (5) q_d.push_back(16'h0077);
      q_if.push_back(16'h5A5A);
      bus.if_addr = 16'h3002;
      bus.d_addr  = 16'h4100;
      bus.d_we    = 1'b0;
      bus.if_req  = 1'b1;
      bus.d_req   = 1'b1;
      nd = 0;
      cyc = 0;
      while (nd < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.if_done) bus.if_req = 1'b0;
         if (bus.d_done) nd++;
      end
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      if (nd < 5) chk("starve_bound", nd, 5);
      chk("starve_cnt_zero", dut.r_starve_cnt, 0);
      chk("starve_gnt_drained", q_gnt.size(), 0);

      // asynchronous reset in the middle of a write
      @(negedge clk);
      mem_auto = 1'b0;
      q_gnt.push_back(mkg(16'h4200, 1'b0, 1'b1, 16'h1234));
      bus.d_we    = 1'b1;
      bus.d_addr  = 16'h4200;
      bus.d_wdata = 16'h1234;
      bus.d_req   = 1'b1;
      cyc = 0;
      while (!bus.mem_wr && cyc < 10) begin @(negedge clk); cyc++; end
      chk("mid_wr_active", bus.mem_wr, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_wr", bus.mem_wr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_d_done", bus.d_done, 0);
      bus.d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_auto = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      fetch(16'h3004, 16'h0E01, cyc);
      chk("post_rst_if_latency", cyc, 2);

`ifdef LC3_ARB_TIMEOUT_EN
      // memory never completes: fetch aborted after TIMEOUT cycles with zero data
      @(negedge clk);
      mem_auto = 1'b0;
      fetch(16'h3006, 16'h0000, cyc);
      chk("tmo_latency", cyc, 17);
      chk("tmo_err_set", err, 1);
      chk("tmo_strobe_low", bus.mem_rd, 0);
      repeat (3) @(negedge clk);
      chk("tmo_err_sticky", err, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("tmo_err_cleared", err, 0);
      rst_n = 1'b1;
      mem_auto = 1'b1;
      @(negedge clk);
`else
      chk("err_tied_low", err, 0);
`endif

      repeat (2) @(negedge clk);
      chk("q_gnt_empty", q_gnt.size(), 0);
      chk("q_if_empty", q_if.size(), 0);
      chk("q_d_empty", q_d.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Arbiter that shares a single LC-3 memory port between the pipeline's instruction-fetch requester and its data-access requester (LD/LDR/LDI/ST/STR/STI, including both phases of indirect accesses). It sits between the fetch/memory-access stages and the external memory interface. It owns the mem_rd/mem_wr strobes and the complete handshake, and returns read data plus a one-cycle done pulse to the granted requester. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while if_req is pending before fetch is forced; range 1..15.
- TIMEOUT, 16: cycles without mem_complete before a transaction is aborted; used only with the macro; range 2..255.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state.
- if_req  in  1  fetch request (read).
- if_addr  in  16  fetch address (PC).
- if_done  out  1  one-cycle pulse: fetch transaction finished.
- if_rdata  out  16  instruction word; valid while if_done=1, held until the next fetch completes.
- d_req  in  1  data request.
- d_we  in  1  1=write, 0=read.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_done  out  1  one-cycle pulse: data transaction finished.
- d_rdata  out  16  read data; valid while d_done=1, held until the next data read completes.
- mem_addr  out  16  memory address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_din  out  16  write data to memory.
- mem_dout  in  16  read data from memory.
- mem_complete  in  1  memory finished the current access.
- busy  out  1  1 when state is not IDLE.
- err  out  1  sticky timeout flag; constant 0 without the macro.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- Requests are sampled only in IDLE. A requester holds req, addr, we and wdata stable until its done pulse.
- req still high in the cycle after done counts as a new request.

IDLE:
- If d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX): go to BUSY_D.
- Else if if_req=1: go to BUSY_I.
- Else: stay in IDLE.

Grant:
- Registered on the transition: mem_addr←selected address; mem_rd←1 for fetch, or for data with d_we=0; mem_wr←d_we for data; mem_din←d_wdata.

BUSY_x, on mem_complete=1:
- Drop mem_rd and mem_wr.
- For a read, latch mem_dout into if_rdata or d_rdata.
- Pulse the owner's done for one cycle.
- Return to IDLE.

Starvation counter (starve_cnt, 4-bit):
- Increments on each data grant made while if_req=1, saturating at 15.
- Clears on a fetch grant, or in IDLE when if_req=0.

Other rules:
- mem_complete is ignored in IDLE.
- mem_rd and mem_wr are never both 1.
- Reset values: all outputs 0; state IDLE; starve_cnt 0; err 0.
- An asynchronous reset during a transaction drops the strobes immediately. No done pulse is issued for that transaction.

## Timing
- Request at edge k (state IDLE): strobes high after edge k.
- mem_complete is sampled at edges k+1 or later.
- Complete sampled at edge m: done and rdata asserted after edge m, strobes low after edge m, state IDLE after edge m.
- Minimum request-to-done latency is 2 cycles. The next grant can occur at edge m+1.
- Throughput: at most one transaction per 2 cycles.

## Configuration
- LC3_ARB_TIMEOUT_EN defined:
  - An 8-bit timer clears on every grant and increments every cycle in BUSY_x.
  - When the timer reaches TIMEOUT-1 with mem_complete=0: strobes drop, the owner's done pulses with rdata=16'h0000, err is set (sticky until reset), and the state returns to IDLE.
  - mem_complete in the same cycle as the timeout wins: normal completion, err unchanged.
- LC3_ARB_TIMEOUT_EN undefined: no timer; BUSY_x waits indefinitely; err tied to 0.

## Structure
- Package lc3_arb_pkg holds:
  - the state enum (IDLE, BUSY_I, BUSY_D);
  - the owner enum (OWN_I, OWN_D);
  - default constants for STARVE_MAX and TIMEOUT;
  - the 16-bit address and data width constants.
- Sub-module lc3_arb_timer holds the timeout counter (clear, enable, expired). It is instantiated only under LC3_ARB_TIMEOUT_EN.

## Test plan
- **Fetch only:** if_req=1 at if_addr=16'h3000; memory completes 1 cycle after mem_rd with 16'h1261 → mem_rd=1 with mem_addr=3000; if_done pulses after 2 cycles; if_rdata=16'h1261.
- **Data write:** d_req=1, d_we=1, d_addr=16'h4000, d_wdata=16'hBEEF → mem_wr=1, mem_rd=0, mem_din=BEEF; d_done pulses; d_rdata unchanged.
- **Simultaneous requests:** if_req and d_req rise together with STARVE_MAX=4 and d_req held high continuously → 4 data grants, then 1 fetch grant, then data resumes; starve_cnt returns to 0.
- **Indirect load:** two back-to-back data reads (LDI: 16'h5000 returns 16'h6000, then 16'h6000 returns 16'h00AA) → two d_done pulses; d_rdata=16'h00AA last; no fetch grant in between unless starve_cnt has reached its limit.
- **Reset mid-transaction:** reset=0 while in BUSY_D → mem_wr, busy and d_done are 0 immediately; after release, the state is IDLE and the next if_req proceeds normally.
- **Timeout (macro on, TIMEOUT=16):** mem_complete is never asserted → after 16 cycles if_done pulses, if_rdata=0000 and err=1; err stays 1 until reset.
